// File: rtl/cache_responder_pkg.sv
// Shared widths, geometry and state encodings for the
// direct-mapped write-through word cache.
package cache_responder_pkg;

    localparam int WORD      = 16;
    localparam int MEMDELAY  = 4;
    localparam int CACHESIZE = 8;
    localparam int IDXW      = $clog2(CACHESIZE);
    localparam int TAGWD     = WORD - IDXW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    function automatic logic [IDXW-1:0] index_of(input logic [WORD-1:0] a);
        return a[IDXW-1:0];
    endfunction

    function automatic logic [TAGWD-1:0] tag_of(input logic [WORD-1:0] a);
        return a[WORD-1:IDXW];
    endfunction

endpackage

// File: rtl/cache_responder_counter.sv
// 16-bit saturating event counter with increment enable.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= 16'h0000;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'h0001;
    end

endmodule

// File: rtl/cache_responder.sv
// Direct-mapped write-through word cache between the processor
// request port and slowmem; read misses fill, writes do not allocate.
module cache_responder
    import cache_responder_pkg::*;
#(
    parameter int LINES = CACHESIZE,
    parameter int TAGW  = WORD - $clog2(LINES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe,
    input  logic        rnotw,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        mfc,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        mem_strobe,
    output logic        mem_rnotw,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_mfc,
    input  logic [15:0] mem_rdata,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int IW = $clog2(LINES);

    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tags [LINES];
    logic [WORD-1:0]  data [LINES];

    state_t          state;
    logic            first_wait;
    logic [WORD-1:0] miss_addr;

    logic [IW-1:0]   idx;
    logic [TAGW-1:0] tag;
    logic [IW-1:0]   fidx;
    logic            hit, accept, rd_hit, rd_miss, wr, fill;

    assign idx     = addr[IW-1:0];
    assign tag     = addr[WORD-1:IW];
    assign fidx    = miss_addr[IW-1:0];
    assign hit     = valid[idx] && (tags[idx] == tag);
    assign accept  = (state == IDLE) && strobe;
    assign rd_hit  = accept && rnotw && hit;
    assign rd_miss = accept && rnotw && !hit;
    assign wr      = accept && !rnotw;
    // slowmem may still hold a stale mfc, so only trust it after the first WAIT cycle
    assign fill    = (state == WAIT) && !first_wait && mem_mfc;

    always_ff @(posedge clk) begin
        if (wr && hit)
            data[idx] <= wdata;
        if (fill) begin
            data[fidx] <= mem_rdata;
            tags[fidx] <= miss_addr[WORD-1:IW];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            first_wait <= 1'b0;
            miss_addr  <= '0;
            mfc        <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            mem_strobe <= 1'b0;
            mem_rnotw  <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mfc        <= 1'b0;
            rdata      <= '0;
            mem_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        rd_hit: begin
                            mfc   <= 1'b1;
                            rdata <= data[idx];
                        end
                        rd_miss: begin
                            mem_strobe <= 1'b1;
                            mem_rnotw  <= 1'b1;
                            mem_addr   <= addr;
                            miss_addr  <= addr;
                            busy       <= 1'b1;
                            state      <= REQ;
                        end
                        wr: begin
                            mem_strobe <= 1'b1;
                            mem_rnotw  <= 1'b0;
                            mem_addr   <= addr;
                            mem_wdata  <= wdata;
                            mfc        <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                REQ: begin
                    mem_rnotw  <= 1'b1;
                    first_wait <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    first_wait <= 1'b0;
                    if (fill) begin
                        valid[fidx] <= 1'b1;
                        mfc         <= 1'b1;
                        rdata       <= mem_rdata;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter16 u_hits (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_hit),
        .count (hit_count)
    );

    sat_counter16 u_misses (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_miss),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_responder.sv
// Directed bench for cache_responder with a 4-cycle slowmem model.
module tb_cache_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic        rnotw = 1'b1;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic        mfc;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_strobe;
    logic        mem_rnotw;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_mfc = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int fails = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    cache_responder dut (
        .clk        (clk),
        .reset      (reset),
        .strobe     (strobe),
        .rnotw      (rnotw),
        .addr       (addr),
        .wdata      (wdata),
        .mfc        (mfc),
        .rdata      (rdata),
        .busy       (busy),
        .mem_strobe (mem_strobe),
        .mem_rnotw  (mem_rnotw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mfc    (mem_mfc),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // slowmem: unwritten word a holds a ^ 16'h5A00; read mfc 4 edges after strobe seen
    logic [15:0] smem [0:65535];
    bit          written [0:65535];
    int          sm_cnt = 0;
    logic [15:0] sm_addr = 16'h0;

    always @(posedge clk) begin
        mem_mfc <= 1'b0;
        if (mem_strobe) strobes++;
        if (mem_strobe) begin
            if (mem_rnotw) begin
                sm_cnt  <= 1;
                sm_addr <= mem_addr;
            end else begin
                smem[mem_addr]    <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end
        end else if (sm_cnt > 0) begin
            if (sm_cnt == 4) begin
                mem_mfc   <= 1'b1;
                mem_rdata <= written[sm_addr] ? smem[sm_addr] : (sm_addr ^ 16'h5A00);
                sm_cnt    <= 0;
            end else begin
                sm_cnt <= sm_cnt + 1;
            end
        end
    end

    task automatic issue(input logic rn, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        strobe = 1'b1;
        rnotw  = rn;
        addr   = a;
        wdata  = d;
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    task automatic wait_mfc(output int n);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (mfc) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mfc !== 1'b0) begin fails++; $display("FAIL rst_mfc: got %b want 0", mfc); end
        checks++; if (rdata !== 16'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (mem_strobe !== 1'b0) begin fails++; $display("FAIL rst_mem_strobe: got %b want 0", mem_strobe); end
        checks++; if (mem_rnotw !== 1'b1) begin fails++; $display("FAIL rst_mem_rnotw: got %b want 1", mem_rnotw); end
        checks++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin fails++; $display("FAIL rst_mem_wdata: got %h want 0000", mem_wdata); end
        checks++; if (hit_count !== 16'h0) begin fails++; $display("FAIL rst_hits: got %h want 0000", hit_count); end
        checks++; if (miss_count !== 16'h0) begin fails++; $display("FAIL rst_misses: got %h want 0000", miss_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_cold_miss;
        int n;
        issue(1'b1, 16'h0010, 16'h0);
        checks++; if (mem_strobe !== 1'b1) begin fails++; $display("FAIL cold_mem_strobe: got %b want 1", mem_strobe); end
        checks++; if (mem_addr !== 16'h0010) begin fails++; $display("FAIL cold_mem_addr: got %h want 0010", mem_addr); end
        checks++; if (mem_rnotw !== 1'b1) begin fails++; $display("FAIL cold_mem_rnotw: got %b want 1", mem_rnotw); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL cold_busy: got %b want 1", busy); end
        checks++; if (mfc !== 1'b0) begin fails++; $display("FAIL cold_early_mfc: got %b want 0", mfc); end
        wait_mfc(n);
        checks++; if (n != 6) begin fails++; $display("FAIL cold_latency: got %0d want 6", n); end
        checks++; if (rdata !== 16'h5A10) begin fails++; $display("FAIL cold_rdata: got %h want 5a10", rdata); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL cold_busy_end: got %b want 0", busy); end
        checks++; if (miss_count !== 16'd1) begin fails++; $display("FAIL cold_misses: got %0d want 1", miss_count); end
        @(posedge clk);
        #1;
        checks++; if (mfc !== 1'b0) begin fails++; $display("FAIL cold_mfc_pulse: got %b want 0", mfc); end
        checks++; if (rdata !== 16'h0) begin fails++; $display("FAIL cold_rdata_idle: got %h want 0000", rdata); end
    endtask

    task automatic test_hit;
        issue(1'b1, 16'h0010, 16'h0);
        checks++; if (mfc !== 1'b1) begin fails++; $display("FAIL hit_mfc: got %b want 1", mfc); end
        checks++; if (rdata !== 16'h5A10) begin fails++; $display("FAIL hit_rdata: got %h want 5a10", rdata); end
        checks++; if (mem_strobe !== 1'b0) begin fails++; $display("FAIL hit_mem_strobe: got %b want 0", mem_strobe); end
        checks++; if (hit_count !== 16'd1) begin fails++; $display("FAIL hit_count: got %0d want 1", hit_count); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL hit_busy: got %b want 0", busy); end
    endtask

    task automatic test_write;
        issue(1'b0, 16'h0010, 16'hBEEF);
        checks++; if (mfc !== 1'b1) begin fails++; $display("FAIL wr_ack: got %b want 1", mfc); end
        checks++; if (rdata !== 16'h0) begin fails++; $display("FAIL wr_rdata: got %h want 0000", rdata); end
        checks++; if (mem_strobe !== 1'b1) begin fails++; $display("FAIL wr_mem_strobe: got %b want 1", mem_strobe); end
        checks++; if (mem_rnotw !== 1'b0) begin fails++; $display("FAIL wr_mem_rnotw: got %b want 0", mem_rnotw); end
        checks++; if (mem_wdata !== 16'hBEEF) begin fails++; $display("FAIL wr_mem_wdata: got %h want beef", mem_wdata); end
        checks++; if (mem_addr !== 16'h0010) begin fails++; $display("FAIL wr_mem_addr: got %h want 0010", mem_addr); end
        issue(1'b1, 16'h0010, 16'h0);
        checks++; if (mfc !== 1'b1) begin fails++; $display("FAIL wr_rd_mfc: got %b want 1", mfc); end
        checks++; if (rdata !== 16'hBEEF) begin fails++; $display("FAIL wr_rd_rdata: got %h want beef", rdata); end
        checks++; if (hit_count !== 16'd2) begin fails++; $display("FAIL wr_rd_hits: got %0d want 2", hit_count); end
        checks++; if (miss_count !== 16'd1) begin fails++; $display("FAIL wr_misses: got %0d want 1", miss_count); end
    endtask

    task automatic test_conflict;
        int n;
        issue(1'b1, 16'h0010, 16'h0);
        checks++; if (rdata !== 16'hBEEF) begin fails++; $display("FAIL cf_hit_rdata: got %h want beef", rdata); end
        issue(1'b1, 16'h0018, 16'h0);
        checks++; if (mem_strobe !== 1'b1) begin fails++; $display("FAIL cf_miss1_strobe: got %b want 1", mem_strobe); end
        wait_mfc(n);
        checks++; if (n != 6) begin fails++; $display("FAIL cf_miss1_latency: got %0d want 6", n); end
        checks++; if (rdata !== 16'h5A18) begin fails++; $display("FAIL cf_miss1_rdata: got %h want 5a18", rdata); end
        issue(1'b1, 16'h0010, 16'h0);
        checks++; if (mem_strobe !== 1'b1) begin fails++; $display("FAIL cf_miss2_strobe: got %b want 1", mem_strobe); end
        wait_mfc(n);
        checks++; if (n != 6) begin fails++; $display("FAIL cf_miss2_latency: got %0d want 6", n); end
        checks++; if (rdata !== 16'hBEEF) begin fails++; $display("FAIL cf_miss2_rdata: got %h want beef", rdata); end
        checks++; if (miss_count !== 16'd3) begin fails++; $display("FAIL cf_misses: got %0d want 3", miss_count); end
        checks++; if (hit_count !== 16'd3) begin fails++; $display("FAIL cf_hits: got %0d want 3", hit_count); end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        strobe = 1'b1; rnotw = 1'b0; addr = 16'h0011; wdata = 16'h1111;
        @(posedge clk);
        #1;
        checks++; if (mfc !== 1'b1) begin fails++; $display("FAIL b2b_ack1: got %b want 1", mfc); end
        checks++; if (mem_addr !== 16'h0011) begin fails++; $display("FAIL b2b_addr1: got %h want 0011", mem_addr); end
        addr = 16'h0012; wdata = 16'h2222;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        checks++; if (mfc !== 1'b1) begin fails++; $display("FAIL b2b_ack2: got %b want 1", mfc); end
        checks++; if (mem_addr !== 16'h0012) begin fails++; $display("FAIL b2b_addr2: got %h want 0012", mem_addr); end
        checks++; if (mem_wdata !== 16'h2222) begin fails++; $display("FAIL b2b_wdata2: got %h want 2222", mem_wdata); end
        @(posedge clk);
        #1;
        checks++; if (mfc !== 1'b0) begin fails++; $display("FAIL b2b_idle_mfc: got %b want 0", mfc); end
        issue(1'b1, 16'h0011, 16'h0);
        checks++; if (mem_strobe !== 1'b1) begin fails++; $display("FAIL b2b_noalloc: got %b want 1", mem_strobe); end
        wait_mfc(n);
        checks++; if (rdata !== 16'h1111) begin fails++; $display("FAIL b2b_rdata: got %h want 1111", rdata); end
        checks++; if (miss_count !== 16'd4) begin fails++; $display("FAIL b2b_misses: got %0d want 4", miss_count); end
    endtask

    task automatic test_busy_drop;
        int n;
        int s0;
        s0 = strobes;
        issue(1'b1, 16'h0030, 16'h0);
        @(negedge clk);
        strobe = 1'b1; rnotw = 1'b1; addr = 16'h0020;
        @(posedge clk);
        @(posedge clk);
        #1;
        strobe = 1'b0;
        wait_mfc(n);
        checks++; if (n != 4) begin fails++; $display("FAIL busy_latency: got %0d want 4", n); end
        checks++; if (rdata !== 16'h5A30) begin fails++; $display("FAIL busy_rdata: got %h want 5a30", rdata); end
        @(posedge clk);
        #1;
        checks++; if (strobes - s0 != 1) begin fails++; $display("FAIL busy_strobes: got %0d want 1", strobes - s0); end
        checks++; if (mfc !== 1'b0) begin fails++; $display("FAIL busy_replay: got %b want 0", mfc); end
        checks++; if (miss_count !== 16'd5) begin fails++; $display("FAIL busy_misses: got %0d want 5", miss_count); end
        checks++; if (hit_count !== 16'd3) begin fails++; $display("FAIL busy_hits: got %0d want 3", hit_count); end
    endtask

    task automatic test_wrap;
        int n;
        issue(1'b1, 16'hFFFF, 16'h0);
        checks++; if (mem_addr !== 16'hFFFF) begin fails++; $display("FAIL wrap_mem_addr: got %h want ffff", mem_addr); end
        wait_mfc(n);
        checks++; if (rdata !== 16'hA5FF) begin fails++; $display("FAIL wrap_miss_rdata: got %h want a5ff", rdata); end
        issue(1'b1, 16'hFFFF, 16'h0);
        checks++; if (mfc !== 1'b1) begin fails++; $display("FAIL wrap_hit_mfc: got %b want 1", mfc); end
        checks++; if (rdata !== 16'hA5FF) begin fails++; $display("FAIL wrap_hit_rdata: got %h want a5ff", rdata); end
        checks++; if (hit_count !== 16'd4) begin fails++; $display("FAIL wrap_hits: got %0d want 4", hit_count); end
    endtask

    task automatic test_reset_mid_miss;
        int n;
        bit saw_mfc;
        bit saw_mem_mfc;
        saw_mfc = 1'b0;
        saw_mem_mfc = 1'b0;
        issue(1'b1, 16'h0021, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (miss_count !== 16'd0) begin fails++; $display("FAIL mid_misses: got %0d want 0", miss_count); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (mfc) saw_mfc = 1'b1;
            if (mem_mfc) saw_mem_mfc = 1'b1;
        end
        checks++; if (saw_mem_mfc !== 1'b1) begin fails++; $display("FAIL mid_late_mem_mfc: got %b want 1", saw_mem_mfc); end
        checks++; if (saw_mfc !== 1'b0) begin fails++; $display("FAIL mid_spurious_mfc: got %b want 0", saw_mfc); end
        issue(1'b1, 16'h0010, 16'h0);
        checks++; if (mem_strobe !== 1'b1) begin fails++; $display("FAIL mid_valid_clr: got %b want 1", mem_strobe); end
        wait_mfc(n);
        checks++; if (rdata !== 16'hBEEF) begin fails++; $display("FAIL mid_refill: got %h want beef", rdata); end
        issue(1'b1, 16'h0021, 16'h0);
        checks++; if (mem_strobe !== 1'b1) begin fails++; $display("FAIL mid_remiss: got %b want 1", mem_strobe); end
        wait_mfc(n);
        checks++; if (n != 6) begin fails++; $display("FAIL mid_latency: got %0d want 6", n); end
        checks++; if (rdata !== 16'h5A21) begin fails++; $display("FAIL mid_rdata: got %h want 5a21", rdata); end
        checks++; if (miss_count !== 16'd2) begin fails++; $display("FAIL mid_misses_end: got %0d want 2", miss_count); end
    endtask

    initial begin
        test_reset;
        test_cold_miss;
        test_hit;
        test_write;
        test_conflict;
        test_back_to_back;
        test_busy_drop;
        test_wrap;
        test_reset_mid_miss;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_responder.md
Name: cache_responder

Overview:
- Direct-mapped, write-through, 8-line word cache that sits between the processor's memory-request port and slowmem.
- Toward the processor it acts as the responder on the strobe/rnotw/addr/wdata → mfc/rdata handshake, using the same signalling as slowmem.
- Toward slowmem it acts as the initiator.
- Read hits answer in 1 cycle. Read misses are forwarded to slowmem and the returned word is filled into the line.

Parameters:
- LINES, 8, number of cache lines; must be a power of two; index = addr[log2(LINES)-1:0].
- TAGW, 13, tag width = 16 - log2(LINES).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- strobe  in  1  processor request valid; sampled only when busy=0.
- rnotw  in  1  1 = read, 0 = write.
- addr  in  16  word address.
- wdata  in  16  write data.
- mfc  out  1  one-cycle completion pulse, for read data or write acknowledge.
- rdata  out  16  read data; valid only while mfc=1, otherwise 16'h0000.
- busy  out  1  miss in progress; strobe is ignored while high.
- mem_strobe  out  1  request to slowmem; one-cycle pulse.
- mem_rnotw  out  1  slowmem read/write select.
- mem_addr  out  16  slowmem address.
- mem_wdata  out  16  slowmem write data.
- mem_mfc  in  1  slowmem completion.
- mem_rdata  in  16  slowmem read data.
- hit_count  out  16  saturating read-hit counter.
- miss_count  out  16  saturating read-miss counter.

Behaviour:
- Reset (async): state=IDLE; all valid bits=0; mfc=0; rdata=0; busy=0; mem_strobe=0; mem_rnotw=1; mem_addr=0; mem_wdata=0; hit_count=0; miss_count=0. Data/tag arrays are not cleared.
- Storage: per line, valid(1), tag(TAGW), data(16). Hit = valid[idx] && tag[idx]==addr[15:log2(LINES)].
- States: IDLE, REQ, WAIT. All outputs are registered.
- IDLE, no strobe: mfc<=0, rdata<=0, mem_strobe<=0.
- IDLE, read hit sampled at edge k:
  - mfc<=1 and rdata<=data[idx], visible after edge k.
  - hit_count++ (saturates at 16'hFFFF).
  - Stay in IDLE.
- IDLE, read miss at edge k:
  - mem_strobe<=1, mem_rnotw<=1, mem_addr<=addr.
  - Latch addr internally; busy<=1; miss_count++ (saturating).
  - Next state REQ.
- IDLE, write at edge k:
  - mem_strobe<=1, mem_rnotw<=0, mem_addr<=addr, mem_wdata<=wdata.
  - On a hit, data[idx]<=wdata. On a miss, no allocate and arrays unchanged.
  - mfc<=1 (write ack), rdata<=0; stay in IDLE; counters unchanged.
- REQ: mem_strobe<=0, mem_rnotw<=1; next state WAIT. mem_mfc is ignored in REQ and in the first WAIT cycle, because slowmem can hold a stale mfc=1.
- WAIT, from the second cycle onward, on mem_mfc=1:
  - Fill the line: valid=1, tag, data=mem_rdata.
  - mfc<=1, rdata<=mem_rdata, busy<=0; next state IDLE.
- Miss latency: with slowmem MEMDELAY=4, a miss sampled at edge k has mem_mfc high after edge k+5 and mfc high after edge k+6. busy is high after edges k..k+5 and low after k+6.
- Earliest next accepted request is at edge k+7.
- Write after write: back-to-back writes on consecutive cycles are accepted, one per cycle, each with its own mfc pulse.
- Strobe while busy=1: dropped with no side effects. The processor must re-issue it.
- mfc is never high for two consecutive cycles unless two requests were accepted on consecutive edges.
- Reset mid-miss: returns to IDLE and valids clear. A late mem_mfc arriving in IDLE is ignored and nothing is filled.
- Address wrap: 16'hFFFF maps to index 7, tag 13'h1FFF. There is no special case.

Decomposition:
- Shared package/header holds WORD, MEMDELAY, CACHESIZE, the state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2), and the TAG/INDEX field-select macros.
- One natural sub-module, sat_counter16 (increment-enable, saturating, async reset), instantiated twice for the counters.

Test Plan:
- Reset, then read 16'h0010 (cold miss) → mem_strobe pulse with mem_addr=16'h0010 after edge k; mfc=1, rdata=m[16'h0010] after edge k+6; miss_count=1.
- Re-read 16'h0010 → mfc=1 after 1 edge with the same data; no mem_strobe; hit_count=1.
- Write 16'h0010←16'hBEEF, then read 16'h0010 → write ack mfc next cycle with mem_rnotw=0; the read hits and returns 16'hBEEF after 1 edge.
- Conflict: read 16'h0010, then read 16'h0018 (same index 0), then read 16'h0010 → second and third reads both miss; miss_count=3.
- Strobe a read of 16'h0020 while busy during a miss → ignored; no second mem_strobe; counters unchanged.
- Assert reset at edge k+3 of a miss → busy=0 and all valids=0 immediately; mem_mfc pulse at k+5 produces no mfc; a following read of the same address misses.
